// File: rtl/reg_bank_mp_pkg.sv
// reg_bank_mp_pkg
// Shared defaults for the multi-port integer register bank: data/index widths,
// register count, stack-pointer and return-register indices, the stack-pointer
// reset value and a register-index type at the default index width.
package reg_bank_mp_pkg;

    localparam int unsigned DataWDef  = 32;
    localparam int unsigned AddrWDef  = 5;
    localparam int unsigned DepthDef  = 32;
    localparam int unsigned SpIdxDef  = 29;
    localparam int unsigned RetIdxDef = 31;
    localparam logic [31:0] SpInitDef = 32'h0000_3FFC;

    typedef logic [AddrWDef-1:0] reg_idx_t;

endpackage

// File: rtl/reg_bank_scoreboard.sv
// reg_bank_scoreboard
// Per-register busy bits for multi-cycle producers (loads, mul/div).
// A claim sets a bit, a write on either port clears it, and a claim wins over a
// write to the same register in the same cycle. Reset clears every bit.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   claim_i/claim_idx_i mark a register busy
//   wr0_en_i/wr0_idx_i  write port 0 (clears busy)
//   wr1_en_i/wr1_idx_i  write port 1 (clears busy)
//   look_a_idx_i/_b_    lookup indices; busy_a_o/busy_b_o return the bits
//                       (0 for indices >= DEPTH and, with ZERO_REG, index 0)
module reg_bank_scoreboard #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DEPTH    = 32,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              claim_i,
    input  logic [ADDR_W-1:0] claim_idx_i,
    input  logic              wr0_en_i,
    input  logic [ADDR_W-1:0] wr0_idx_i,
    input  logic              wr1_en_i,
    input  logic [ADDR_W-1:0] wr1_idx_i,
    input  logic [ADDR_W-1:0] look_a_idx_i,
    input  logic [ADDR_W-1:0] look_b_idx_i,
    output logic              busy_a_o,
    output logic              busy_b_o
);

    logic [DEPTH-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr0_en_i && wr0_idx_i == ADDR_W'(i)) busy_d[i] = 1'b0;
            if (wr1_en_i && wr1_idx_i == ADDR_W'(i)) busy_d[i] = 1'b0;
            // Applied last so a new producer wins over a retiring one.
            if (claim_i && claim_idx_i == ADDR_W'(i)) busy_d[i] = 1'b1;
        end
        if (ZERO_REG) busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Loop-compare lookup: indices outside the array fall through to 0.
    always_comb begin
        busy_a_o = 1'b0;
        busy_b_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (look_a_idx_i == ADDR_W'(i)) busy_a_o = busy_q[i];
            if (look_b_idx_i == ADDR_W'(i)) busy_b_o = busy_q[i];
        end
    end

endmodule

// File: rtl/reg_bank_mp.sv
// reg_bank_mp
// CPU integer register file: two combinational read ports, two synchronous
// write ports (port 1 wins on an index collision), a per-register busy
// scoreboard, and stack-pointer / return-register taps.
//
// Optional feature macro: REG_BANK_BYPASS_EN
//   defined   - same-cycle write data is forwarded to rs_out, rt_out, sp and
//               retReg (port 1 over port 0); busy outputs are never forwarded.
//   undefined - outputs reflect register contents as of the last rising edge.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   rs/rt -> rs_out/rt_out         read data
//   rs_busy/rt_busy                scoreboard bits of rs/rt
//   regWrite/writeReg/writeData    write port 0 (ALU writeback)
//   regWrite2/writeReg2/writeData2 write port 1 (memory/long-latency writeback)
//   claim/claimReg                 mark a register busy
//   sp/retReg                      contents of SP_IDX / RET_IDX
module reg_bank_mp
    import reg_bank_mp_pkg::*;
#(
    parameter int unsigned DATA_W   = DataWDef,
    parameter int unsigned ADDR_W   = AddrWDef,
    parameter int unsigned DEPTH    = DepthDef,
    parameter int unsigned SP_IDX   = SpIdxDef,
    parameter int unsigned RET_IDX  = RetIdxDef,
    parameter logic [31:0] SP_INIT  = SpInitDef,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] rs_out,
    output logic [DATA_W-1:0] rt_out,
    output logic              rs_busy,
    output logic              rt_busy,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic              regWrite2,
    input  logic [ADDR_W-1:0] writeReg2,
    input  logic [DATA_W-1:0] writeData2,
    input  logic              claim,
    input  logic [ADDR_W-1:0] claimReg,
    output logic [DATA_W-1:0] sp,
    output logic [DATA_W-1:0] retReg
);

    localparam logic [ADDR_W-1:0] SpIdx      = ADDR_W'(SP_IDX);
    localparam logic [ADDR_W-1:0] RetIdx     = ADDR_W'(RET_IDX);
    localparam logic [DATA_W-1:0] SpInitData = DATA_W'(SP_INIT);

    // A write is real only if enabled, in range and not aimed at a hard-wired zero.
    function automatic logic write_ok(input logic en, input logic [ADDR_W-1:0] idx);
        logic in_range;
        in_range = 32'(idx) < DEPTH;
        return en && in_range && !(ZERO_REG && idx == '0);
    endfunction

    logic wr0_ok, wr1_ok, claim_ok;

    assign wr0_ok   = write_ok(regWrite, writeReg);
    assign wr1_ok   = write_ok(regWrite2, writeReg2);
    assign claim_ok = write_ok(claim, claimReg);

    // ------------------------------------------------------------------
    // Data array
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr0_ok && writeReg == ADDR_W'(i))  regs_d[i] = writeData;
            // Port 1 is applied second so it wins a collision.
            if (wr1_ok && writeReg2 == ADDR_W'(i)) regs_d[i] = writeData2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= (i == SP_IDX) ? SpInitData : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // ------------------------------------------------------------------
    // Registered reads (index >= DEPTH, or index 0 with ZERO_REG, give 0)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rs_stored, rt_stored, sp_stored, ret_stored;

    always_comb begin
        rs_stored  = '0;
        rt_stored  = '0;
        sp_stored  = '0;
        ret_stored = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!(ZERO_REG && i == 0)) begin
                if (rs == ADDR_W'(i))     rs_stored  = regs_q[i];
                if (rt == ADDR_W'(i))     rt_stored  = regs_q[i];
                if (SpIdx == ADDR_W'(i))  sp_stored  = regs_q[i];
                if (RetIdx == ADDR_W'(i)) ret_stored = regs_q[i];
            end
        end
    end

`ifdef REG_BANK_BYPASS_EN
    // Forward the same-cycle write to a matching read index, port 1 first.
    function automatic logic [DATA_W-1:0] fwd(
        input logic [ADDR_W-1:0] idx,
        input logic [DATA_W-1:0] stored,
        input logic              w0_ok,
        input logic [ADDR_W-1:0] w0_idx,
        input logic [DATA_W-1:0] w0_data,
        input logic              w1_ok,
        input logic [ADDR_W-1:0] w1_idx,
        input logic [DATA_W-1:0] w1_data
    );
        if (w1_ok && w1_idx == idx) return w1_data;
        if (w0_ok && w0_idx == idx) return w0_data;
        return stored;
    endfunction

    assign rs_out = fwd(rs, rs_stored, wr0_ok, writeReg, writeData,
                        wr1_ok, writeReg2, writeData2);
    assign rt_out = fwd(rt, rt_stored, wr0_ok, writeReg, writeData,
                        wr1_ok, writeReg2, writeData2);
    assign sp     = fwd(SpIdx, sp_stored, wr0_ok, writeReg, writeData,
                        wr1_ok, writeReg2, writeData2);
    assign retReg = fwd(RetIdx, ret_stored, wr0_ok, writeReg, writeData,
                        wr1_ok, writeReg2, writeData2);
`else
    assign rs_out = rs_stored;
    assign rt_out = rt_stored;
    assign sp     = sp_stored;
    assign retReg = ret_stored;
`endif

    // ------------------------------------------------------------------
    // Busy scoreboard (writes/claims pre-filtered for range and zero reg)
    // ------------------------------------------------------------------
    reg_bank_scoreboard #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk_i        (clk),
        .rst_i        (rst),
        .claim_i      (claim_ok),
        .claim_idx_i  (claimReg),
        .wr0_en_i     (wr0_ok),
        .wr0_idx_i    (writeReg),
        .wr1_en_i     (wr1_ok),
        .wr1_idx_i    (writeReg2),
        .look_a_idx_i (rs),
        .look_b_idx_i (rt),
        .busy_a_o     (rs_busy),
        .busy_b_o     (rt_busy)
    );

endmodule

// File: tb/tb_reg_bank_mp.sv
// tb_reg_bank_mp
// Directed table-driven bench for reg_bank_mp plus hand sequences for
// same-cycle forwarding (expectations depend on REG_BANK_BYPASS_EN).
module tb_reg_bank_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs, rt, writeReg, writeReg2, claimReg;
    logic [31:0] rs_out, rt_out, writeData, writeData2, sp, retReg;
    logic        rs_busy, rt_busy, regWrite, regWrite2, claim;

    int total = 0;
    int bad   = 0;

    reg_bank_mp dut (
        .clk        (clk),
        .rst        (rst),
        .rs         (rs),
        .rt         (rt),
        .rs_out     (rs_out),
        .rt_out     (rt_out),
        .rs_busy    (rs_busy),
        .rt_busy    (rt_busy),
        .regWrite   (regWrite),
        .writeReg   (writeReg),
        .writeData  (writeData),
        .regWrite2  (regWrite2),
        .writeReg2  (writeReg2),
        .writeData2 (writeData2),
        .claim      (claim),
        .claimReg   (claimReg),
        .sp         (sp),
        .retReg     (retReg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        we0;
        logic [4:0]  wr0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wr1;
        logic [31:0] wd1;
        logic        cl;
        logic [4:0]  creg;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        logic        e_rsb;
        logic        e_rtb;
        logic [31:0] e_sp;
        logic [31:0] e_ret;
    } vec_t;

    localparam int NVec = 13;
    vec_t vecs [NVec];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst       = 1'b0;
        regWrite  = 1'b0;
        regWrite2 = 1'b0;
        claim     = 1'b0;
    endtask

    initial begin
        // rst rs rt we0 wr0 wd0 we1 wr1 wd1 cl creg | rs_out rt_out rsb rtb sp ret
        vecs[0]  = '{1, 4, 0, 1, 4, 32'hDEAD_0004, 0, 0, 0, 1, 4,
                     0, 0, 0, 0, 32'h3FFC, 0};
        vecs[1]  = '{0, 4, 5, 1, 4, 32'h1234_5678, 0, 0, 0, 0, 0,
                     32'h1234_5678, 0, 0, 0, 32'h3FFC, 0};
        vecs[2]  = '{0, 31, 4, 1, 31, 32'hAABB_CCDD, 0, 0, 0, 0, 0,
                     32'hAABB_CCDD, 32'h1234_5678, 0, 0, 32'h3FFC, 32'hAABB_CCDD};
        vecs[3]  = '{0, 7, 29, 1, 7, 32'h1111_1111, 1, 7, 32'h2222_2222, 0, 0,
                     32'h2222_2222, 32'h3FFC, 0, 0, 32'h3FFC, 32'hAABB_CCDD};
        vecs[4]  = '{0, 0, 7, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0,
                     0, 32'h2222_2222, 0, 0, 32'h3FFC, 32'hAABB_CCDD};
        vecs[5]  = '{0, 9, 9, 0, 0, 0, 0, 0, 0, 1, 9,
                     0, 0, 1, 1, 32'h3FFC, 32'hAABB_CCDD};
        vecs[6]  = '{0, 9, 4, 0, 0, 0, 1, 9, 32'h0000_CAFE, 0, 0,
                     32'h0000_CAFE, 32'h1234_5678, 0, 0, 32'h3FFC, 32'hAABB_CCDD};
        vecs[7]  = '{0, 9, 0, 1, 9, 32'h0000_1234, 0, 0, 0, 1, 9,
                     32'h0000_1234, 0, 1, 0, 32'h3FFC, 32'hAABB_CCDD};
        vecs[8]  = '{0, 9, 12, 0, 0, 0, 0, 0, 0, 1, 9,
                     32'h0000_1234, 0, 1, 0, 32'h3FFC, 32'hAABB_CCDD};
        vecs[9]  = '{0, 12, 13, 1, 12, 32'h0000_AAAA, 1, 13, 32'h0000_BBBB, 1, 12,
                     32'h0000_AAAA, 32'h0000_BBBB, 1, 0, 32'h3FFC, 32'hAABB_CCDD};
        vecs[10] = '{0, 9, 12, 1, 9, 32'h0000_0077, 0, 0, 0, 0, 0,
                     32'h0000_0077, 32'h0000_AAAA, 0, 1, 32'h3FFC, 32'hAABB_CCDD};
        vecs[11] = '{0, 29, 3, 1, 29, 32'h0000_5555, 1, 3, 32'h0000_0005, 1, 20,
                     32'h0000_5555, 32'h0000_0005, 0, 0, 32'h0000_5555, 32'hAABB_CCDD};
        vecs[12] = '{0, 20, 12, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 32'h0000_AAAA, 1, 1, 32'h0000_5555, 32'hAABB_CCDD};

        idle_inputs();
        rs = '0; rt = '0; writeReg = '0; writeReg2 = '0; claimReg = '0;
        writeData = '0; writeData2 = '0;

        for (int i = 0; i < NVec; i++) begin
            @(negedge clk);
            rst        = vecs[i].rst;
            rs         = vecs[i].rs;
            rt         = vecs[i].rt;
            regWrite   = vecs[i].we0;
            writeReg   = vecs[i].wr0;
            writeData  = vecs[i].wd0;
            regWrite2  = vecs[i].we1;
            writeReg2  = vecs[i].wr1;
            writeData2 = vecs[i].wd1;
            claim      = vecs[i].cl;
            claimReg   = vecs[i].creg;
            @(posedge clk);
            #1;
            idle_inputs();
            #1;
            chk($sformatf("v%0d rs_out", i), rs_out, vecs[i].e_rs);
            chk($sformatf("v%0d rt_out", i), rt_out, vecs[i].e_rt);
            chk($sformatf("v%0d rs_busy", i), 32'(rs_busy), 32'(vecs[i].e_rsb));
            chk($sformatf("v%0d rt_busy", i), 32'(rt_busy), 32'(vecs[i].e_rtb));
            chk($sformatf("v%0d sp", i), sp, vecs[i].e_sp);
            chk($sformatf("v%0d retReg", i), retReg, vecs[i].e_ret);
        end

        // Forwarding, port 0: reg 3 holds 5. Claim is not forwarded to busy.
        @(negedge clk);
        rs = 5'd3; rt = 5'd29;
        regWrite = 1'b1; writeReg = 5'd3; writeData = 32'h0000_BEEF;
        regWrite2 = 1'b1; writeReg2 = 5'd29; writeData2 = 32'h0000_6666;
        claim = 1'b1; claimReg = 5'd3;
        #1;
`ifdef REG_BANK_BYPASS_EN
        chk("fwd0 pre rs_out", rs_out, 32'h0000_BEEF);
        chk("fwd0 pre sp", sp, 32'h0000_6666);
`else
        chk("fwd0 pre rs_out", rs_out, 32'h0000_0005);
        chk("fwd0 pre sp", sp, 32'h0000_5555);
`endif
        chk("fwd0 pre rs_busy", 32'(rs_busy), 32'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        chk("fwd0 post rs_out", rs_out, 32'h0000_BEEF);
        chk("fwd0 post sp", sp, 32'h0000_6666);
        chk("fwd0 post rs_busy", 32'(rs_busy), 32'd1);

        // Forwarding priority: both ports to reg 3, port 1 wins.
        @(negedge clk);
        regWrite = 1'b1; writeReg = 5'd3; writeData = 32'h0000_0001;
        regWrite2 = 1'b1; writeReg2 = 5'd3; writeData2 = 32'h0000_F00D;
        #1;
`ifdef REG_BANK_BYPASS_EN
        chk("fwd1 pre rs_out", rs_out, 32'h0000_F00D);
`else
        chk("fwd1 pre rs_out", rs_out, 32'h0000_BEEF);
`endif
        chk("fwd1 pre rs_busy", 32'(rs_busy), 32'd1);
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        chk("fwd1 post rs_out", rs_out, 32'h0000_F00D);
        chk("fwd1 post rs_busy", 32'(rs_busy), 32'd0);

        // Reset wins over a same-cycle write and claim.
        @(negedge clk);
        rst = 1'b1; rs = 5'd3; rt = 5'd12;
        regWrite2 = 1'b1; writeReg2 = 5'd3; writeData2 = 32'h0000_9999;
        claim = 1'b1; claimReg = 5'd12;
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        chk("rst2 rs_out", rs_out, 32'h0);
        chk("rst2 rt_busy", 32'(rt_busy), 32'd0);
        chk("rst2 sp", sp, 32'h0000_3FFC);
        chk("rst2 retReg", retReg, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
